// File: rtl/led_pattern_counter.sv
// led_pattern_counter: prescaled LED stepper that shows binary, Gray, ring or bounce patterns.
// Latency: a step updates led/tick/wrap on the edge where it is evaluated; buttons add sync+debounce+pulse delay.
// Backpressure: none; free-running display, steps are never queued (clear wins over a coincident step).
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_en                    1 = free-run from prescaler, 0 = prescaler frozen and step button active
//   i_dir                   1 = up/left, 0 = down/right (ignored in bounce mode)
//   i_speed                 prescaler terminal count is (DIV >> i_speed) - 1
//   i_mode                  00 binary, 01 Gray, 10 ring, 11 bounce
//   i_btn_step, i_btn_clear raw asynchronous buttons
//   o_led                   registered display
//   o_tick, o_wrap          one-cycle pulses on a new step / on wrap-around

// lpc_debounce: two-flop synchronizer, stable-count debouncer, rising-edge press pulse.
// Latency: press pulse is high during the cycle after edge DB_CYCLES+3 of a held input.
// Backpressure: none; each accepted press yields exactly one pulse.
module lpc_debounce #(
    parameter int DB_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_dbc;
    logic            r_db;
    logic            r_db_d;
    logic            r_press;
    logic            w_s;

    assign w_s     = r_sync[1];
    assign o_press = r_press;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync  <= 2'b00;
            r_dbc   <= '0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // The counter only runs while the synchronized level disagrees
            // with the accepted level; any return to agreement restarts it.
            if (w_s == r_db) begin
                r_dbc <= '0;
            end else if (r_dbc == DB_LAST) begin
                r_db  <= w_s;
                r_dbc <= '0;
            end else begin
                r_dbc <= r_dbc + DB_W'(1);
            end
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
        end
    end
endmodule

module led_pattern_counter #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int WIDTH     = 8,
    parameter int DB_CYCLES = 500_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic [1:0]       i_speed,
    input  logic [1:0]       i_mode,
    input  logic             i_btn_step,
    input  logic             i_btn_clear,
    output logic [WIDTH-1:0] o_led,
    output logic             o_tick,
    output logic             o_wrap
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0] MODE_BIN    = 2'b00;
    localparam logic [1:0] MODE_GRAY   = 2'b01;
    localparam logic [1:0] MODE_RING   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    logic [PRE_W-1:0] r_pre;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_pat;
    logic             r_bdir;
    logic [WIDTH-1:0] r_led;
    logic             r_tick;
    logic             r_wrap;

    logic             w_step_press;
    logic             w_clear;
    logic [31:0]      w_term;
    logic             w_pre_step;
    logic             w_step;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_pat_nxt;
    logic             w_bdir_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_led_nxt;

    lpc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_step),
        .o_press (w_step_press)
    );

    lpc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn_clear),
        .o_press (w_clear)
    );

    // Greater-or-equal compare so that lowering the terminal count mid-period
    // steps on the very next edge instead of running the counter round.
    assign w_term     = (32'(DIV) >> i_speed) - 32'd1;
    assign w_pre_step = i_en & (32'(r_pre) >= w_term);
    // Button steps only count while free-run is off.
    assign w_step     = w_pre_step | (w_step_press & ~i_en);

    always_comb begin
        w_pre_nxt  = r_pre;
        w_cnt_nxt  = r_cnt;
        w_pat_nxt  = r_pat;
        w_bdir_nxt = r_bdir;
        w_wrap_nxt = 1'b0;
        w_led_nxt  = '0;

        if (w_clear) begin
            w_pre_nxt = '0;
        end else if (i_en) begin
            w_pre_nxt = w_pre_step ? '0 : r_pre + PRE_W'(1);
        end

        if (w_clear) begin
            w_cnt_nxt  = '0;
            w_pat_nxt  = WIDTH'(1);
            w_bdir_nxt = 1'b1;
        end else if (w_step) begin
            case (i_mode)
                MODE_BIN, MODE_GRAY: begin
                    if (i_dir) begin
                        w_cnt_nxt  = r_cnt + WIDTH'(1);
                        w_wrap_nxt = &r_cnt;
                    end else begin
                        w_cnt_nxt  = r_cnt - WIDTH'(1);
                        w_wrap_nxt = ~|r_cnt;
                    end
                end
                MODE_RING: begin
                    // An all-zero pattern can never move again; reseed it.
                    if (r_pat == '0) begin
                        w_pat_nxt = WIDTH'(1);
                    end else if (i_dir) begin
                        w_pat_nxt  = {r_pat[WIDTH-2:0], r_pat[WIDTH-1]};
                        w_wrap_nxt = r_pat[WIDTH-1];
                    end else begin
                        w_pat_nxt  = {r_pat[0], r_pat[WIDTH-1:1]};
                        w_wrap_nxt = r_pat[0];
                    end
                end
                default: begin
                    // Bounce: reverse at either end, never wrap.
                    if (r_pat == '0) begin
                        w_pat_nxt = WIDTH'(1);
                    end else if (r_bdir & r_pat[WIDTH-1]) begin
                        w_bdir_nxt = 1'b0;
                        w_pat_nxt  = r_pat >> 1;
                    end else if (!r_bdir & r_pat[0]) begin
                        w_bdir_nxt = 1'b1;
                        w_pat_nxt  = r_pat << 1;
                    end else if (r_bdir) begin
                        w_pat_nxt  = r_pat << 1;
                    end else begin
                        w_pat_nxt  = r_pat >> 1;
                    end
                end
            endcase
        end

        case (i_mode)
            MODE_BIN:    w_led_nxt = w_cnt_nxt;
            MODE_GRAY:   w_led_nxt = w_cnt_nxt ^ (w_cnt_nxt >> 1);
            MODE_RING,
            MODE_BOUNCE: w_led_nxt = w_pat_nxt;
            default:     w_led_nxt = w_cnt_nxt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pre  <= '0;
            r_cnt  <= '0;
            r_pat  <= WIDTH'(1);
            r_bdir <= 1'b1;
            r_led  <= '0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_pre  <= w_pre_nxt;
            r_cnt  <= w_cnt_nxt;
            r_pat  <= w_pat_nxt;
            r_bdir <= w_bdir_nxt;
            r_led  <= w_led_nxt;
            r_tick <= w_step & ~w_clear;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_led  = r_led;
    assign o_tick = r_tick;
    assign o_wrap = r_wrap;
endmodule

// File: tb/tb_led_pattern_counter.sv
// tb_led_pattern_counter: scenario tasks driving led_pattern_counter against a position-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_led_pattern_counter;
    localparam int W   = 4;
    localparam int DIV = 16;
    localparam int DB  = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         dir;
    logic [1:0]   speed;
    logic [1:0]   mode;
    logic         btn_step;
    logic         btn_clear;
    logic [W-1:0] led;
    logic         tick;
    logic         wrap;

    int total = 0;
    int bad   = 0;

    // Reference model: counter value, one-hot position and bounce heading.
    int           m_pre;
    int           m_cnt;
    int           m_pos;
    int           m_bd;
    logic [W-1:0] m_led;
    logic         m_tick;
    logic         m_wrap;

    always #5 clk = ~clk;

    led_pattern_counter #(
        .CLK_HZ(16), .TICK_HZ(1), .WIDTH(W), .DB_CYCLES(DB)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_dir       (dir),
        .i_speed     (speed),
        .i_mode      (mode),
        .i_btn_step  (btn_step),
        .i_btn_clear (btn_clear),
        .o_led       (led),
        .o_tick      (tick),
        .o_wrap      (wrap)
    );

    task automatic model_reset();
        m_pre = 0; m_cnt = 0; m_pos = 0; m_bd = 1;
        m_led = '0; m_tick = 1'b0; m_wrap = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge(input bit clr);
        int t;
        bit st;
        t  = (DIV >> speed) - 1;
        st = 1'b0;
        if (clr) m_pre = 0;
        else if (en) begin
            if (m_pre >= t) begin st = 1'b1; m_pre = 0; end
            else m_pre++;
        end
        m_tick = 1'b0;
        m_wrap = 1'b0;
        if (clr) begin
            m_cnt = 0; m_pos = 0; m_bd = 1;
        end else if (st) begin
            m_tick = 1'b1;
            if (mode <= 2'd1) begin
                if (dir) begin m_wrap = (m_cnt == 15); m_cnt = (m_cnt + 1) % 16; end
                else     begin m_wrap = (m_cnt == 0);  m_cnt = (m_cnt + 15) % 16; end
            end else if (mode == 2'd2) begin
                if (dir) begin m_wrap = (m_pos == W-1); m_pos = (m_pos + 1) % W; end
                else     begin m_wrap = (m_pos == 0);   m_pos = (m_pos + W - 1) % W; end
            end else begin
                if (m_bd == 1 && m_pos == W-1) m_bd = 0;
                else if (m_bd == 0 && m_pos == 0) m_bd = 1;
                m_pos = m_pos + ((m_bd == 1) ? 1 : -1);
            end
        end
        case (mode)
            2'd0:    m_led = W'(m_cnt);
            2'd1:    m_led = W'(m_cnt ^ (m_cnt >> 1));
            default: m_led = W'(1 << m_pos);
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        mode = 2'b10; en = 1'b1; dir = 1'b1; speed = 2'd0;
        btn_step = 1'b0; btn_clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (led !== 4'b0000) begin bad++; $display("FAIL reset_led got=%b want=0000", led); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b want=0", wrap); end
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); model_edge(1'b0); #1;
        total++; if (led !== 4'b0001) begin bad++; $display("FAIL reset_first_ring got=%b want=0001", led); end
    endtask

    task automatic test_binary_up();
        int last, wraps;
        mode = 2'b00; en = 1'b1; dir = 1'b1; speed = 2'd0;
        do_reset();
        last = -1; wraps = 0;
        for (int e = 1; e <= 16*17 + 4; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (led !== m_led || tick !== m_tick || wrap !== m_wrap) begin
                bad++; $display("FAIL bin_up e=%0d led=%h/%h tick=%b/%b wrap=%b/%b", e, led, m_led, tick, m_tick, wrap, m_wrap);
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    total++; if (e - last != 16) begin bad++; $display("FAIL bin_period got=%0d want=16", e - last); end
                end
                last = e;
            end
            if (wrap === 1'b1) begin
                wraps++;
                total++; if (led !== 4'h0) begin bad++; $display("FAIL bin_wrap_led got=%h want=0", led); end
            end
        end
        total++; if (wraps != 1) begin bad++; $display("FAIL bin_wrap_count got=%0d want=1", wraps); end
    endtask

    task automatic test_down_fast();
        logic [3:0] el [6] = '{4'd0, 4'd15, 4'd15, 4'd14, 4'd14, 4'd13};
        logic       et [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic       ew [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        mode = 2'b00; en = 1'b1; dir = 1'b0; speed = 2'd3;
        do_reset();
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (led !== el[e] || tick !== et[e] || wrap !== ew[e]) begin
                bad++; $display("FAIL down_fast e=%0d led=%h/%h tick=%b/%b wrap=%b/%b", e+1, led, el[e], tick, et[e], wrap, ew[e]);
            end
        end
    endtask

    task automatic test_gray();
        mode = 2'b01; en = 1'b1; dir = 1'b1; speed = 2'd3;
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (led !== m_led) begin bad++; $display("FAIL gray e=%0d got=%b want=%b", e, led, m_led); end
            if (e == 10) begin
                total++; if (led !== 4'b0111) begin bad++; $display("FAIL gray_5 got=%b want=0111", led); end
            end
            if (e == 12) begin
                total++; if (led !== 4'b0101 || tick !== 1'b1) begin bad++; $display("FAIL gray_6 got=%b/%b want=0101/1", led, tick); end
            end
        end
        mode = 2'b00;
        @(posedge clk); model_edge(1'b0); #1;
        total++; if (led !== 4'b0110 || tick !== 1'b0) begin
            bad++; $display("FAIL gray_to_bin got=%b tick=%b want=0110 tick=0", led, tick);
        end
    endtask

    task automatic test_bounce();
        logic [3:0] seq [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        mode = 2'b11; en = 1'b1; dir = 1'b1; speed = 2'd3;
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (wrap !== 1'b0) begin bad++; $display("FAIL bounce_wrap e=%0d got=%b want=0", e, wrap); end
            total++; if (led !== m_led) begin bad++; $display("FAIL bounce_model e=%0d got=%b want=%b", e, led, m_led); end
            if (e == 1 || e % 2 == 0) begin
                total++; if (led !== seq[e/2]) begin bad++; $display("FAIL bounce_seq e=%0d got=%b want=%b", e, led, seq[e/2]); end
            end
            dir = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_ring();
        mode = 2'b10; en = 1'b1; dir = 1'b1; speed = 2'd3;
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (led !== m_led || tick !== m_tick || wrap !== m_wrap) begin
                bad++; $display("FAIL ring e=%0d led=%b/%b tick=%b/%b wrap=%b/%b", e, led, m_led, tick, m_tick, wrap, m_wrap);
            end
            if ($urandom_range(0, 3) == 0) dir = ~dir;
        end
    endtask

    task automatic test_random();
        mode = 2'b00; en = 1'b1; dir = 1'b1; speed = 2'd2;
        do_reset();
        for (int e = 1; e <= 1500; e++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (led !== m_led || tick !== m_tick || wrap !== m_wrap) begin
                bad++; $display("FAIL random e=%0d m=%0d s=%0d led=%h/%h tick=%b/%b wrap=%b/%b", e, mode, speed, led, m_led, tick, m_tick, wrap, m_wrap);
            end
            if ($urandom_range(0, 7) == 0) mode  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) speed = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) dir   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) en   = ~en;
        end
    endtask

    task automatic test_step_button();
        mode = 2'b00; en = 1'b0; dir = 1'b1; speed = 2'd0;
        do_reset();
        btn_step = 1'b1;
        for (int e = 1; e <= 23; e++) begin
            @(posedge clk); #1;
            total++; if (led !== 4'd0 || tick !== 1'b0) begin bad++; $display("FAIL step_glitch e=%0d led=%h tick=%b want 0/0", e, led, tick); end
            if (e == 3) btn_step = 1'b0;
        end
        btn_step = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            total++; if (tick !== (k == 8)) begin bad++; $display("FAIL step_tick k=%0d got=%b want=%b", k, tick, (k == 8)); end
            total++; if (led !== ((k >= 8) ? 4'd1 : 4'd0)) begin bad++; $display("FAIL step_led k=%0d got=%h want=%0d", k, led, (k >= 8)); end
            if (k == 10) btn_step = 1'b0;
        end
    endtask

    task automatic test_clear();
        mode = 2'b00; en = 1'b1; dir = 1'b1; speed = 2'd0;
        btn_step = 1'b0; btn_clear = 1'b0;
        do_reset();
        for (int e = 1; e <= 212; e++) begin
            @(posedge clk); model_edge(e == 160); #1;
            total++; if (led !== m_led || tick !== m_tick || wrap !== m_wrap) begin
                bad++; $display("FAIL clear_model e=%0d led=%h/%h tick=%b/%b", e, led, m_led, tick, m_tick);
            end
            if (e == 159) begin
                total++; if (led !== 4'd9) begin bad++; $display("FAIL clear_pre got=%h want=9", led); end
            end
            if (e == 160) begin
                total++; if (led !== 4'd0 || tick !== 1'b0) begin bad++; $display("FAIL clear_hit led=%h tick=%b want 0/0", led, tick); end
            end
            if (e == 212) begin
                total++; if (led !== 4'd3) begin bad++; $display("FAIL clear_cnt3 got=%h want=3", led); end
            end
            if (e == 152) btn_clear = 1'b1;
            if (e == 160) btn_clear = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (led !== 4'd0) begin bad++; $display("FAIL midrst_led got=%h want=0", led); end
        model_reset();
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); model_edge(1'b0); #1;
            total++; if (tick !== (k == 16)) begin bad++; $display("FAIL midrst_tick k=%0d got=%b want=%b", k, tick, (k == 16)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; dir = 1'b1; speed = 2'd0; mode = 2'b00;
        btn_step = 1'b0; btn_clear = 1'b0;
        model_reset();
        test_reset();
        test_binary_up();
        test_down_fast();
        test_gray();
        test_bounce();
        test_ring();
        test_random();
        test_step_button();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
